// File: rtl/xoodyak_pkg.sv
// rtl/xoodyak_pkg.sv - shared types and helpers for the xoodyak result drain
package xoodyak_pkg;

  localparam int         TEXT_W      = 192;
  localparam logic [7:0] HDR_TAG_DEF = 8'hA5;

  typedef enum logic [4:0] {
    OP_IDLE    = 5'd0,
    OP_INIT    = 5'd1,
    OP_NONCE   = 5'd2,
    OP_ASSOC   = 5'd3,
    OP_CRYPT   = 5'd4,
    OP_DECRYPT = 5'd5,
    OP_SQUEEZE = 5'd6,
    OP_RATCHET = 5'd7
  } opmode_e;

  typedef struct packed {
    logic [4:0]        opmode;
    logic [TEXT_W-1:0] text;
  } rec_t;

  function automatic logic [7:0] payload_len(input logic [4:0] op);
    case (op)
      OP_CRYPT, OP_DECRYPT: return 8'd6;
      OP_SQUEEZE:           return 8'd4;
      default:              return 8'd0;
    endcase
  endfunction

  // Squeeze uses the top four words only, so both record kinds index from the MSW.
  function automatic logic [31:0] payload_word(input rec_t r, input logic [2:0] idx);
    logic [TEXT_W-1:0] t;
    t = r.text << {idx, 5'b00000};
    return t[TEXT_W-1 -: 32];
  endfunction

endpackage

// File: rtl/xoodyak_result_drain_if.sv
// rtl/xoodyak_result_drain_if.sv - result word stream toward the host
interface xoodyak_result_drain_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/xoodyak_rec_fifo.sv
// rtl/xoodyak_rec_fifo.sv - DEPTH-entry result record FIFO with wrap-bit pointers
module xoodyak_rec_fifo
  import xoodyak_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  rec_t                     push_rec,
  input  logic                     pop,
  output rec_t                     head,
  output rec_t                     next_head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] nxt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_rec;
  end

  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign count     = wr_ptr - rd_ptr;
  assign nxt_idx   = rd_ptr[AW-1:0] + AW'(1);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign next_head = mem[nxt_idx];

endmodule

// File: rtl/xoodyak_result_drain.sv
// rtl/xoodyak_result_drain.sv - buffers finished xoodyak results and streams them as framed 32-bit words
module xoodyak_result_drain
  import xoodyak_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEF
) (
  input  logic                          eph1,
  input  logic                          reset,
  input  logic [4:0]                    opmode,
  input  logic [TEXT_W-1:0]             textout,
  input  logic                          finished,
  xoodyak_result_drain_if.master        out,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  state_t        state;
  logic [2:0]    idx;
  rec_t          head;
  rec_t          next_head;
  rec_t          in_rec;
  rec_t          next_rec;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          next_avail;
  logic [7:0]    len;

  function automatic logic [31:0] hdr_word(input rec_t r);
    return {HDR_TAG, 3'b000, r.opmode, 8'h00, payload_len(r.opmode)};
  endfunction

  assign in_rec    = '{opmode: opmode, text: textout};
  assign push      = finished && !full;
  assign pop       = out.out_valid && out.out_ready && out.out_last;
  assign fifo_full = full;
  assign len       = payload_len(head.opmode);

  // A record pushed while the head is popped becomes the next head, so chain straight to it.
  assign next_avail = (count > CW'(1)) || push;
  assign next_rec   = (count > CW'(1)) ? next_head : in_rec;

  xoodyak_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (eph1),
    .rst_n     (reset),
    .push      (push),
    .push_rec  (in_rec),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
      out.out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state         <= S_HDR;
            out.out_valid <= 1'b1;
            out.out_data  <= hdr_word(head);
            out.out_last  <= (len == 8'd0);
          end
        end
        default: begin
          if (out.out_ready) begin
            if (out.out_last) begin
              if (next_avail) begin
                state        <= S_HDR;
                out.out_data <= hdr_word(next_rec);
                out.out_last <= (payload_len(next_rec.opmode) == 8'd0);
              end else begin
                state         <= S_IDLE;
                out.out_valid <= 1'b0;
                out.out_last  <= 1'b0;
              end
            end else if (state == S_HDR) begin
              state        <= S_PAY;
              idx          <= '0;
              out.out_data <= payload_word(head, 3'd0);
              out.out_last <= (len == 8'd1);
            end else begin
              idx          <= idx + 3'd1;
              out.out_data <= payload_word(head, idx + 3'd1);
              out.out_last <= (({5'd0, idx} + 8'd2) == len);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (finished && full) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/xoodyak_result_drain.md
Name: xoodyak_result_drain

Overview:
- Output-side counterpart of the xoodyak_build command interface: captures each completed operation result from the core and serialises it to the host.
- Samples textout/opmode on every finished pulse and buffers whole result records in a small FIFO.
- Drains records as 32-bit words on a valid/ready stream, each record framed by a header word and a last flag.
- Sits between xoodyak_build outputs and the host/bus readback logic.

Parameters:
DEPTH, 4, number of buffered result records (power of 2, >=2)
HDR_TAG, 8'hA5, constant placed in header bits [31:24]

Ports:
eph1  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
opmode  input  5  opmode in effect when finished asserts (0 idle, 1 init, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet)
textout  input  192  core text/tag output, valid in finished cycle
finished  input  1  one-cycle pulse, result valid
out_data  output  32  stream word
out_valid  output  1  out_data valid
out_ready  input  1  host accepts word when valid&ready
out_last  output  1  final word of current record
fifo_full  output  1  DEPTH records held
overflow  output  1  sticky, a finished pulse was dropped
drop_cnt  output  8  saturating count of dropped records

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM IDLE, out_valid=0, out_last=0, out_data=0, fifo_full=0, overflow=0, drop_cnt=0. Reset mid-record discards all buffered data; partial records are never resumed.
- Capture: finished=1 and FIFO not full -> push {opmode, textout} that cycle. Full evaluated on pre-cycle count; a pop completing in the same cycle does NOT free space for that push (drop). Full-and-finished -> overflow<=1, drop_cnt+=1 saturating at 8'hFF.
- Payload length by opmode: 4/5 -> 6 words, textout[191:0] MSW first; 6 -> 4 words, textout[191:64] MSW first; all others -> 0 words (header only).
- Header word: {HDR_TAG, 3'b000, opmode, 8'h00, len[7:0]}.
- FSM IDLE: FIFO non-empty -> HDR (registered, one cycle later).
- FSM HDR: out_valid=1, out_data=header, out_last=(len==0). On accept: len==0 -> pop, go to IDLE (or straight to HDR if another record is waiting); else -> PAY, word index=0.
- FSM PAY: out_data=payload word[idx], out_last=(idx==len-1). On accept: idx+1; on last accept -> pop, then HDR if FIFO still non-empty else IDLE.
- Latency: finished at edge N into empty FIFO -> header with out_valid=1 after edge N+1. Back-to-back records have no idle cycle between the last word and the next header.
- Stream rules: once out_valid=1, out_data/out_last are held stable until accepted; out_valid never drops without a handshake except on reset.
- Pointers: log2(DEPTH)-bit rd/wr plus one wrap bit. Full = pointers equal and wrap bits differ; empty = pointers equal and wrap bits equal. Simultaneous push+pop on a non-full FIFO keeps count unchanged.
- fifo_full is combinational from pointers. overflow clears only on reset.

Decomposition:
- Shared package xoodyak_pkg: opmode enum (OP_IDLE..OP_RATCHET), record struct {opmode, text[191:0]}, payload length function, HDR_TAG default.
- Sub-module xoodyak_rec_fifo: DEPTH-entry record FIFO with push/pop/full/empty, pointer/wrap logic. FSM and serialiser stay in the top.

Test Plan:
- Single crypt: finished, opmode=4, textout=192'h4d4e4f5051525354555657584142434445464748494a4b4c, out_ready=1 -> A5040006, 4d4e4f50, 51525354, 55565758, 41424344, 45464748, 494a4b4c; out_last on the final word only; first word 1 cycle after finished.
- Squeeze plus header-only: opmode=6, textout=192'h87a06d5561b0d87c20a12db5d34783258ff75fe5d87c0e30 -> A5060004, 87a06d55, 61b0d87c, 20a12db5, d3478325; then opmode=2 -> A5020000 with out_last=1.
- Backpressure: out_ready toggles 1010 during a decrypt record -> each word held stable while waiting, word order unchanged, 7 total words.
- Overflow: out_ready=0, 5 finished pulses with DEPTH=4 -> fifo_full=1, overflow=1, drop_cnt=1; after release, exactly the first 4 records drain in order.
- Full with simultaneous pop: full FIFO, finished in the same cycle the last word of the head record is accepted -> record dropped, drop_cnt increments, count becomes 3.
- Async reset mid-PAY: reset=0 between clock edges -> out_valid=0 immediately, FIFO empty; after release, no stale words appear until a new finished pulse.
